// File: rtl/cart_scan_pkg.sv
// Shared types and constants for the cartridge scan controller.
// Covers the FSM states, A2601top force_bs codes and the image-size table.
package cart_scan_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DECIDE, DONE} scan_state_t;

  localparam logic [3:0] BS_NONE = 4'd0;
  localparam logic [3:0] BS_F8   = 4'd1;
  localparam logic [3:0] BS_F6   = 4'd2;
  localparam logic [3:0] BS_FE   = 4'd3;
  localparam logic [3:0] BS_E0   = 4'd4;
  localparam logic [3:0] BS_3F   = 4'd5;
  localparam logic [3:0] BS_F4   = 4'd6;
  localparam logic [3:0] BS_P2   = 4'd7;
  localparam logic [3:0] BS_FA   = 4'd8;
  localparam logic [3:0] BS_CV   = 4'd9;
  localparam logic [3:0] BS_UA   = 4'd11;
  localparam logic [3:0] BS_E7   = 4'd12;
  localparam logic [3:0] BS_F0   = 4'd13;
  localparam logic [3:0] BS_32   = 4'd14;

  localparam logic [16:0] SZ_4K     = 17'd4096;
  localparam logic [16:0] SZ_8K     = 17'd8192;
  localparam logic [16:0] SZ_P2_MIN = 17'd10240;
  localparam logic [16:0] SZ_P2_MAX = 17'd10495;
  localparam logic [16:0] SZ_12K    = 17'd12288;
  localparam logic [16:0] SZ_16K    = 17'd16384;
  localparam logic [16:0] SZ_32K    = 17'd32768;
  localparam logic [16:0] SZ_64K    = 17'h10000;

  // Sizes that match no known layout fall back to the plain 4K mapper.
  function automatic logic [3:0] size_to_bs(input logic [16:0] size);
    logic [3:0] code;
    if (size <= SZ_4K)                            code = BS_NONE;
    else if (size == SZ_8K)                       code = BS_F8;
    else if (size >= SZ_P2_MIN && size <= SZ_P2_MAX) code = BS_P2;
    else if (size == SZ_12K)                      code = BS_FA;
    else if (size == SZ_16K)                      code = BS_F6;
    else if (size == SZ_32K)                      code = BS_F4;
    else if (size == SZ_64K)                      code = BS_F0;
    else                                          code = BS_NONE;
    return code;
  endfunction

endpackage

// File: rtl/cart_sig_match.sv
// Byte-signature counters for 8K bankswitch detection (3-byte window).
// Only built when CART_SCAN_SIGS_EN is defined.
`ifdef CART_SCAN_SIGS_EN
module cart_sig_match #(
  parameter int SIG_CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 data_valid,
  input  logic [7:0]           data,
  output logic [SIG_CNT_W-1:0] c3f,
  output logic [SIG_CNT_W-1:0] ce0,
  output logic [SIG_CNT_W-1:0] cfe
);

  logic [7:0] w1, w2;
  logic       hit_3f, hit_e0, hit_fe;

  // A zeroed window can never form the first byte of any pattern.
  always_comb begin
    hit_3f = (w1 == 8'h85) && (data == 8'h3F);
    hit_e0 = (w2 == 8'h8D || w2 == 8'hAD) && (w1 == 8'hE0) &&
             (data == 8'h1F || data == 8'hFF);
    hit_fe = (w2 == 8'h20) && (w1 == 8'h00) && (data == 8'hD0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w1  <= 8'h00;
      w2  <= 8'h00;
      c3f <= '0;
      ce0 <= '0;
      cfe <= '0;
    end else if (clear) begin
      w1  <= 8'h00;
      w2  <= 8'h00;
      c3f <= '0;
      ce0 <= '0;
      cfe <= '0;
    end else if (data_valid) begin
      w2 <= w1;
      w1 <= data;
      if (hit_3f && c3f != '1) c3f <= c3f + 1'b1;
      if (hit_e0 && ce0 != '1) ce0 <= ce0 + 1'b1;
      if (hit_fe && cfe != '1) cfe <= cfe + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/cart_scan_ctl.sv
// Post-download cartridge controller: sizes the image, scans ROM RAM, picks bs/sc.
// Define CART_SCAN_SIGS_EN to enable signature-based 8K bankswitch detection.
module cart_scan_ctl
  import cart_scan_pkg::*;
#(
  parameter int SC_PROBE_LEN = 256,
  parameter int SIG_CNT_W    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [3:0]  ext_bs,
  input  logic        sc_ext,
  input  logic [1:0]  sc_mode,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [3:0]  bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        cpu_hold,
  output logic        done
);

  localparam logic [16:0] PROBE_LEN = 17'(SC_PROBE_LEN);

  scan_state_t state;
  logic        dl_prev, rd_dly, sc_match, sc_ext_q;
  logic [16:0] size, scan_len, issue_cnt, data_idx;
  logic [7:0]  byte0;
  logic [3:0]  ext_bs_q, decide_bs;
  logic [1:0]  sc_mode_q;
  logic        dl_rise, dl_fall, sc_pat, decide_sc;
  logic [16:0] wr_len, size_upd, scan_len_next;

  // Image length is the highest written address plus one, capped at 64K.
  always_comb begin
    dl_rise  = ioctl_download & ~dl_prev;
    dl_fall  = ~ioctl_download & dl_prev;
    wr_len   = ioctl_addr[16] ? SZ_64K : ({1'b0, ioctl_addr[15:0]} + 17'd1);
    size_upd = (ioctl_wr && wr_len > size) ? wr_len : size;
    scan_len_next = (ext_bs_q != BS_NONE && size_upd > PROBE_LEN) ? PROBE_LEN : size_upd;
    sc_pat   = (size >= PROBE_LEN) && sc_match;
  end

`ifdef CART_SCAN_SIGS_EN
  logic [SIG_CNT_W-1:0] c3f, ce0, cfe;

  cart_sig_match #(.SIG_CNT_W(SIG_CNT_W)) u_sig (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (state == LOAD),
    .data_valid (state == SCAN && rd_dly),
    .data       (mem_data),
    .c3f        (c3f),
    .ce0        (ce0),
    .cfe        (cfe)
  );
`endif

  always_comb begin
    decide_bs = (ext_bs_q != BS_NONE) ? ext_bs_q : size_to_bs(size);
`ifdef CART_SCAN_SIGS_EN
    if (ext_bs_q == BS_NONE && size == SZ_8K) begin
      if (cfe != '0)                   decide_bs = BS_FE;
      else if (c3f >= SIG_CNT_W'(2))   decide_bs = BS_3F;
      else if (ce0 != '0)              decide_bs = BS_E0;
    end
`endif
    case (sc_mode_q)
      2'd0:    decide_sc = sc_ext_q | sc_pat;
      2'd1:    decide_sc = 1'b0;
      default: decide_sc = 1'b1;
    endcase
  end

  // A new download start pre-empts every state except LOAD itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dl_prev   <= 1'b0;
      rd_dly    <= 1'b0;
      size      <= '0;
      scan_len  <= '0;
      issue_cnt <= '0;
      data_idx  <= '0;
      byte0     <= 8'h00;
      sc_match  <= 1'b0;
      ext_bs_q  <= BS_NONE;
      sc_ext_q  <= 1'b0;
      sc_mode_q <= 2'd0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      bs        <= BS_NONE;
      sc        <= 1'b0;
      rom_size  <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      rd_dly  <= mem_rd;
      done    <= 1'b0;
      if (dl_rise && state != LOAD) begin
        state     <= LOAD;
        size      <= '0;
        ext_bs_q  <= ext_bs;
        sc_ext_q  <= sc_ext;
        sc_mode_q <= sc_mode;
        cpu_hold  <= 1'b1;
        mem_rd    <= 1'b0;
        mem_addr  <= '0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            size <= size_upd;
            if (dl_fall) begin
              if (size_upd == '0) begin
                state <= DECIDE;
              end else begin
                state     <= SCAN;
                scan_len  <= scan_len_next;
                mem_rd    <= 1'b1;
                mem_addr  <= '0;
                issue_cnt <= 17'd1;
                data_idx  <= '0;
                sc_match  <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (issue_cnt < scan_len) begin
              mem_rd    <= 1'b1;
              mem_addr  <= issue_cnt[15:0];
              issue_cnt <= issue_cnt + 17'd1;
            end else begin
              mem_rd <= 1'b0;
            end
            if (rd_dly) begin
              data_idx <= data_idx + 17'd1;
              if (data_idx == '0)
                byte0 <= mem_data;
              else if (data_idx < PROBE_LEN && mem_data != byte0)
                sc_match <= 1'b0;
            end
            // Read issue has stopped, so this cycle consumes the final byte.
            if (!mem_rd) state <= DECIDE;
          end
          DECIDE: begin
            bs       <= decide_bs;
            sc       <= decide_sc;
            rom_size <= size;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart_scan_ctl.sv
// Scoreboard bench for cart_scan_ctl: directed loads push expected decisions,
// a monitor pops and compares on every done pulse.
module tb_cart_scan_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [3:0]  ext_bs;
  logic        sc_ext;
  logic [1:0]  sc_mode;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic [3:0]  bs;
  logic        sc;
  logic [16:0] rom_size;
  logic        cpu_hold, done;

  logic [7:0] rom [0:65535];

  typedef struct {
    logic [3:0] bs;
    logic       sc;
    int         rom_size;
    int         reads;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

`ifdef CART_SCAN_SIGS_EN
  localparam logic [3:0] EXP_8K_SIG_BS = 4'd5;
`else
  localparam logic [3:0] EXP_8K_SIG_BS = 4'd1;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

  cart_scan_ctl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ext_bs         (ext_bs),
    .sc_ext         (sc_ext),
    .sc_mode        (sc_mode),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .bs             (bs),
    .sc             (sc),
    .rom_size       (rom_size),
    .cpu_hold       (cpu_hold),
    .done           (done)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: counts scan reads since the last download start and scores each done.
  int   rd_cnt;
  bit   hold_ok;
  logic dl_seen;
  exp_t cur;
  initial begin
    rd_cnt = 0; hold_ok = 1'b1; dl_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_cnt  = 0;
        dl_seen = ioctl_download;
      end else begin
        if (mem_rd) begin
          rd_cnt++;
          if (!cpu_hold) hold_ok = 1'b0;
        end
        if (ioctl_download && !dl_seen) begin
          rd_cnt  = 0;
          hold_ok = 1'b1;
        end
        dl_seen = ioctl_download;
        if (done) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_done", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check_output("bs", int'(bs), int'(cur.bs));
            check_output("sc", int'(sc), int'(cur.sc));
            check_output("rom_size", int'(rom_size), cur.rom_size);
            check_output("read_count", rd_cnt, cur.reads);
            check_output("hold_during_scan", int'(hold_ok), 1);
            check_output("hold_released", int'(cpu_hold), 0);
          end
        end
      end
    end
  end

  task automatic start_download(input logic [3:0] e, input logic se, input logic [1:0] m);
    @(negedge clk);
    ext_bs = e; sc_ext = se; sc_mode = m; ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  // Highest address first so later lower writes exercise the max tracking.
  task automatic write_size(input int len);
    int addrs [3];
    addrs[0] = len - 1; addrs[1] = 0; addrs[2] = len / 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ioctl_wr = 1'b1; ioctl_addr = addrs[i][16:0];
      @(negedge clk);
      ioctl_wr = 1'b0;
    end
  endtask

  task automatic end_download();
    @(negedge clk);
    ioctl_download = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_in_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_scan_addr(input logic [15:0] a, input int limit);
    int n = 0;
    while (!(mem_rd && mem_addr == a) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output("scan_reached", int'(mem_rd && mem_addr == a), 1);
  endtask

  task automatic apply_stimulus(input int len, input logic [3:0] e, input logic se,
                                input logic [1:0] m, input logic [3:0] xbs,
                                input logic xsc, input int xreads);
    exp_t x;
    x.bs = xbs; x.sc = xsc; x.rom_size = len; x.reads = xreads;
    exp_q.push_back(x);
    start_download(e, se, m);
    write_size(len);
    end_download();
    wait_drain(2 * len + 200);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_bs"}, int'(bs), 0);
    check_output({tag, "_sc"}, int'(sc), 0);
    check_output({tag, "_rom_size"}, int'(rom_size), 0);
    check_output({tag, "_cpu_hold"}, int'(cpu_hold), 0);
    check_output({tag, "_done"}, int'(done), 0);
    check_output({tag, "_mem_rd"}, int'(mem_rd), 0);
    check_output({tag, "_mem_addr"}, int'(mem_addr), 0);
  endtask

  initial begin
    exp_t x;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ext_bs = '0; sc_ext = 1'b0; sc_mode = 2'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    $display("[TB] 4K auto image");
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[1] = rom[0] ^ 8'h01;
    apply_stimulus(4096, 4'd0, 1'b0, 2'd0, 4'd0, 1'b0, 4096);

    $display("[TB] SuperChip probe cases");
    for (int i = 0; i < 2048; i++) rom[i] = (i < 256) ? 8'hFF : 8'($urandom);
    apply_stimulus(2048, 4'd0, 1'b0, 2'd0, 4'd0, 1'b1, 2048);
    apply_stimulus(2048, 4'd0, 1'b0, 2'd1, 4'd0, 1'b0, 2048);
    apply_stimulus(100, 4'd0, 1'b1, 2'd0, 4'd0, 1'b1, 100);
    apply_stimulus(100, 4'd0, 1'b0, 2'd0, 4'd0, 1'b0, 100);
    apply_stimulus(100, 4'd14, 1'b0, 2'd2, 4'd14, 1'b1, 100);

    $display("[TB] 8K signature image");
    for (int i = 0; i < 8192; i++) rom[i] = 8'hEA;
    rom[5] = 8'h00;
    rom[16'h0100] = 8'h85; rom[16'h0101] = 8'h3F;
    rom[16'h0200] = 8'h85; rom[16'h0201] = 8'h3F;
    apply_stimulus(8192, 4'd0, 1'b0, 2'd0, EXP_8K_SIG_BS, 1'b0, 8192);
    apply_stimulus(8192, 4'd9, 1'b0, 2'd0, 4'd9, 1'b0, 256);

    $display("[TB] async reset mid-scan");
    for (int i = 0; i < 16384; i++) rom[i] = 8'(i) ^ 8'h5A;
    start_download(4'd0, 1'b0, 2'd0);
    write_size(16384);
    end_download();
    wait_scan_addr(16'h0800, 20000);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    apply_stimulus(16384, 4'd0, 1'b0, 2'd0, 4'd2, 1'b0, 16384);

    $display("[TB] abort mid-scan then 12K image");
    for (int i = 0; i < 32768; i++) rom[i] = 8'(i);
    start_download(4'd0, 1'b0, 2'd0);
    write_size(32768);
    end_download();
    wait_scan_addr(16'h0400, 40000);
    start_download(4'd0, 1'b0, 2'd0);
    check_output("abort_mem_rd", int'(mem_rd), 0);
    check_output("abort_cpu_hold", int'(cpu_hold), 1);
    check_output("abort_bs_kept", int'(bs), 2);
    x.bs = 4'd8; x.sc = 1'b0; x.rom_size = 12288; x.reads = 12288;
    exp_q.push_back(x);
    write_size(12288);
    end_download();
    wait_drain(30000);

    $display("[TB] P2 size range");
    apply_stimulus(10300, 4'd0, 1'b0, 2'd0, 4'd7, 1'b0, 10300);

    repeat (5) @(negedge clk);
    check_output("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
